// File: rtl/aes_pkg.sv
// Shared AES helpers: block geometry, packer state encoding and PKCS#7 fill.
// The downstream unpacker reuses this package for pad stripping.
package aes_pkg;

    localparam int AES_BLOCK_BYTES = 16;

    localparam logic [1:0] STATE_FILL = 2'd0;
    localparam logic [1:0] STATE_PAD  = 2'd1;
    localparam logic [1:0] STATE_OUT  = 2'd2;

    typedef enum logic [1:0] {
        FILL = STATE_FILL,
        PAD  = STATE_PAD,
        OUT  = STATE_OUT
    } packer_state_e;

    // PKCS#7 pad byte for a block holding 'count' real bytes (0x01..0x10).
    function automatic logic [7:0] pkcs7_pad_value(input logic [4:0] count);
        return 8'(AES_BLOCK_BYTES) - {3'b000, count};
    endfunction

    // Keeps slots 0..count-1 of 'block' and fills the rest with the pad
    // value (pad_en=1) or zeros (pad_en=0). Slot k sits at [127-8k -: 8].
    function automatic logic [127:0] pkcs7_fill(input logic [127:0] block,
                                                input logic [4:0]   count,
                                                input logic         pad_en);
        logic [7:0]   fillByte;
        logic [127:0] result;
        fillByte = pad_en ? pkcs7_pad_value(count) : 8'h00;
        result   = block;
        for (int k = 0; k < AES_BLOCK_BYTES; k++) begin
            if (5'(k) >= count) begin
                result[127-8*k -: 8] = fillByte;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/aes_block_packer_if.sv
// Byte-stream input and 128-bit block output of the AES block packer.
// The slave modport is the packer; the master modport is its environment.
interface aes_block_packer_if;
    import aes_pkg::*;

    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_data;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         out_last;
    logic [4:0]   out_count;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_count
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last, out_count
    );

endinterface

// File: rtl/aes_block_packer.sv
// Packs a byte stream MSB-first into 128-bit AES plaintext blocks, applying
// PKCS#7 padding (or zero fill) at message end. Fill and drain never overlap.
module aes_block_packer
    import aes_pkg::*;
#(
    parameter int BLOCK_BYTES = AES_BLOCK_BYTES,
    parameter bit PAD_EN      = 1'b1
) (
    input logic              clk,
    input logic              rst,
    aes_block_packer_if.slave bus
);

    localparam logic [4:0] FULL_COUNT = 5'(BLOCK_BYTES);

    packer_state_e state_q, state_d;
    logic [4:0]    count_q, count_d;
    logic          padPending_q, padPending_d;
    logic [127:0]  outData_q, outData_d;
    logic          outLast_q, outLast_d;
    logic [4:0]    outCount_q, outCount_d;
    logic [4:0]    countInc;

    // Handshake flags come straight from the state; data outputs are registers.
    assign bus.in_ready  = (state_q == FILL);
    assign bus.out_valid = (state_q == OUT);
    assign bus.out_data  = outData_q;
    assign bus.out_last  = outLast_q;
    assign bus.out_count = outCount_q;

    // Next-state logic: byte-slot writes in FILL, pad fill in PAD, drain in OUT.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        padPending_d = padPending_q;
        outData_d    = outData_q;
        outLast_d    = outLast_q;
        outCount_d   = outCount_q;
        countInc     = count_q + 5'd1;

        case (state_q)
            FILL: begin
                if (bus.in_valid) begin
                    for (int k = 0; k < AES_BLOCK_BYTES; k++) begin
                        if (count_q == 5'(k)) begin
                            outData_d[127-8*k -: 8] = bus.in_data;
                        end
                    end
                    count_d = countInc;
                    if (countInc == FULL_COUNT) begin
                        state_d      = OUT;
                        outCount_d   = FULL_COUNT;
                        outLast_d    = bus.in_last && !PAD_EN;
                        padPending_d = bus.in_last && PAD_EN;
                    end else if (bus.in_last) begin
                        state_d = PAD;
                    end
                end
            end
            PAD: begin
                outData_d  = pkcs7_fill(outData_q, count_q, PAD_EN);
                outCount_d = count_q;
                outLast_d  = 1'b1;
                state_d    = OUT;
            end
            OUT: begin
                if (bus.out_ready) begin
                    if (padPending_q) begin
                        outData_d    = {AES_BLOCK_BYTES{8'h10}};
                        outCount_d   = 5'd0;
                        outLast_d    = 1'b1;
                        padPending_d = 1'b0;
                    end else begin
                        count_d   = 5'd0;
                        outData_d = '0;
                        state_d   = FILL;
                    end
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    // State register; reset drops any partial or pending pad block.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FILL;
            count_q      <= 5'd0;
            padPending_q <= 1'b0;
            outData_q    <= '0;
            outLast_q    <= 1'b0;
            outCount_q   <= 5'd0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            padPending_q <= padPending_d;
            outData_q    <= outData_d;
            outLast_q    <= outLast_d;
            outCount_q   <= outCount_d;
        end
    end

endmodule

// File: tb/tb_aes_block_packer.sv
// Directed bench for aes_block_packer: one padding and one zero-fill instance,
// expected blocks come from a byte-level model pushed into a scoreboard.
module tb_aes_block_packer;
    import aes_pkg::*;

    typedef struct packed {
        logic [127:0] data;
        logic         last;
        logic [4:0]   count;
    } blk_t;

    logic       clk;
    logic       rst;
    logic       sel;
    logic       inValid;
    logic [7:0] inData;
    logic       inLast;
    logic       outReady;

    int total = 0;
    int bad   = 0;

    blk_t       sb[$];
    logic [7:0] partBytes[$];

    aes_block_packer_if ifPad();
    aes_block_packer_if ifZero();

    // sel=0 steers stimulus to the padding instance, sel=1 to the zero-fill one.
    assign ifPad.in_valid   = inValid && !sel;
    assign ifPad.in_data    = inData;
    assign ifPad.in_last    = inLast;
    assign ifPad.out_ready  = outReady && !sel;
    assign ifZero.in_valid  = inValid && sel;
    assign ifZero.in_data   = inData;
    assign ifZero.in_last   = inLast;
    assign ifZero.out_ready = outReady && sel;

    logic         obsInReady, obsOutValid, obsOutLast;
    logic [127:0] obsOutData;
    logic [4:0]   obsOutCount;
    assign obsInReady  = sel ? ifZero.in_ready  : ifPad.in_ready;
    assign obsOutValid = sel ? ifZero.out_valid : ifPad.out_valid;
    assign obsOutData  = sel ? ifZero.out_data  : ifPad.out_data;
    assign obsOutLast  = sel ? ifZero.out_last  : ifPad.out_last;
    assign obsOutCount = sel ? ifZero.out_count : ifPad.out_count;

    aes_block_packer #(.BLOCK_BYTES(16), .PAD_EN(1'b1)) dutPad (
        .clk(clk), .rst(rst), .bus(ifPad)
    );

    aes_block_packer #(.BLOCK_BYTES(16), .PAD_EN(1'b0)) dutZero (
        .clk(clk), .rst(rst), .bus(ifZero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: collects message bytes and queues the blocks they form.
    task automatic modelByte(input logic [7:0] d, input logic l);
        blk_t       b;
        int         n;
        logic [7:0] fillVal;
        partBytes.push_back(d);
        n = partBytes.size();
        if (n == 16) begin
            for (int k = 0; k < 16; k++) b.data[127-8*k -: 8] = partBytes[k];
            b.last  = l && sel;
            b.count = 5'd16;
            sb.push_back(b);
            if (l && !sel) begin
                b.data  = {16{8'h10}};
                b.last  = 1'b1;
                b.count = 5'd0;
                sb.push_back(b);
            end
            partBytes.delete();
        end else if (l) begin
            fillVal = sel ? 8'h00 : 8'(16 - n);
            for (int k = 0; k < 16; k++)
                b.data[127-8*k -: 8] = (k < n) ? partBytes[k] : fillVal;
            b.last  = 1'b1;
            b.count = 5'(n);
            sb.push_back(b);
            partBytes.delete();
        end
    endtask

    // Offers one byte for exactly one edge; the packer must be ready for it.
    task automatic applyStimulus(input logic [7:0] d, input logic l);
        chk("in_ready_before_byte", 128'(obsInReady), 128'(1'b1));
        inValid = 1'b1;
        inData  = d;
        inLast  = l;
        @(posedge clk); #1;
        inValid = 1'b0;
        inLast  = 1'b0;
        modelByte(d, l);
    endtask

    // Waits for a block, checks latency and contents, holds it for holdCycles
    // with out_ready low, then takes it.
    task automatic checkOutput(input int expLat, input int holdCycles);
        int   lat;
        blk_t e;
        lat = 1;
        while (!obsOutValid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", 128'(lat), 128'(expLat));
        chk("out_valid", 128'(obsOutValid), 128'(1'b1));
        if (sb.size() == 0) begin
            chk("scoreboard_underflow", 128'(0), 128'(1));
            e = '0;
        end else begin
            e = sb.pop_front();
        end
        chk("out_data", obsOutData, e.data);
        chk("out_last", 128'(obsOutLast), 128'(e.last));
        chk("out_count", 128'(obsOutCount), 128'(e.count));
        chk("in_ready_while_out", 128'(obsInReady), 128'(1'b0));
        for (int i = 0; i < holdCycles; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", 128'(obsOutValid), 128'(1'b1));
            chk("hold_data", obsOutData, e.data);
            chk("hold_in_ready", 128'(obsInReady), 128'(1'b0));
        end
        outReady = 1'b1;
        @(posedge clk); #1;
        outReady = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        sel      = 1'b0;
        inValid  = 1'b0;
        inData   = 8'h00;
        inLast   = 1'b0;
        outReady = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_out_valid", 128'(obsOutValid), 128'(1'b0));
        chk("reset_in_ready", 128'(obsInReady), 128'(1'b1));
        chk("reset_out_data", obsOutData, 128'(0));
        chk("reset_out_last", 128'(obsOutLast), 128'(1'b0));
        chk("reset_out_count", 128'(obsOutCount), 128'(0));

        // Full block, no end of message.
        for (int i = 0; i < 16; i++) applyStimulus(8'(i), 1'b0);
        checkOutput(1, 0);
        chk("fill_after_full", 128'(obsInReady), 128'(1'b1));

        // Short final block padded with 0x0B.
        for (int i = 1; i <= 5; i++) applyStimulus(8'(i), i == 5);
        checkOutput(2, 0);

        // Exact 16-byte message: data block then a full pad block.
        for (int i = 0; i < 16; i++) applyStimulus(8'hAA, i == 15);
        checkOutput(1, 0);
        checkOutput(1, 0);
        chk("fill_after_pad_block", 128'(obsInReady), 128'(1'b1));

        // Zero-fill instance: exact block is final, short block is zero-filled.
        sel = 1'b1;
        for (int i = 0; i < 16; i++) applyStimulus(8'hAA, i == 15);
        checkOutput(1, 0);
        chk("zero_fill_ready", 128'(obsInReady), 128'(1'b1));
        applyStimulus(8'hC1, 1'b0);
        applyStimulus(8'hC2, 1'b0);
        applyStimulus(8'hC3, 1'b1);
        checkOutput(2, 0);

        // Backpressure with a byte offered the whole time the block waits.
        sel = 1'b0;
        for (int i = 0; i < 16; i++) applyStimulus(8'(3 * i + 7), 1'b0);
        inValid = 1'b1;
        inData  = 8'h55;
        checkOutput(1, 10);
        applyStimulus(8'h55, 1'b0);
        for (int i = 1; i < 16; i++) applyStimulus(8'(8'h60 + i), 1'b0);
        checkOutput(1, 0);

        // Reset in the middle of a block discards the partial bytes.
        for (int i = 0; i < 7; i++) applyStimulus(8'(8'h80 + i), 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        partBytes.delete();
        chk("midreset_out_valid", 128'(obsOutValid), 128'(1'b0));
        chk("midreset_in_ready", 128'(obsInReady), 128'(1'b1));
        for (int i = 0; i < 16; i++) applyStimulus(8'(8'hF0 + i), 1'b0);
        checkOutput(1, 0);

        chk("scoreboard_empty", 128'(sb.size()), 128'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
